// File: rtl/cnn_pkg.sv
// Shared types for the 3x3 convolution datapath (window generator and conv core).
package cnn_pkg;

  localparam int CNN_DATA_WIDTH   = 8;
  localparam int CNN_NUM_CHANNELS = 3;

  typedef logic signed [CNN_DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t pix_vec_t [CNN_NUM_CHANNELS];
  typedef pixel_t window_t [CNN_NUM_CHANNELS][3][3];

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } win_state_e;

endpackage

// File: rtl/line_buffer.sv
// Single-channel line store, one sample per column. The read port is
// combinational so a sample can be read and overwritten at the same column
// in one cycle (read-before-write).
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  logic signed [DATA_WIDTH-1:0] mem_r [DEPTH];

  assign rd_data = mem_r[addr];

  // Store the incoming sample; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Raster-order pixel stream to 3x3xNUM_CHANNELS sliding window ("valid"
// convolution, stride 1). Two line buffers per channel feed the upper rows
// of a per-channel 3x3 shift window.
module conv3x3_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH   = CNN_DATA_WIDTH,
  parameter int NUM_CHANNELS = CNN_NUM_CHANNELS,
  parameter int IMG_WIDTH    = 32,
  parameter int IMG_HEIGHT   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic signed [DATA_WIDTH-1:0] pix_in [0:NUM_CHANNELS-1],
  output logic signed [DATA_WIDTH-1:0] window [0:NUM_CHANNELS-1][0:2][0:2],
  output logic                         window_valid,
  output logic                         frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  win_state_e state_r;
  win_state_e state_next_s;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic accept_s;
  logic col_last_s;
  logic fill_done_s;
  logic beat_last_s;
  logic win_hit_s;
  logic ready_next_s;
  logic pix_ready_r;
  logic window_valid_r;
  logic frame_done_r;
  logic signed [DATA_WIDTH-1:0] line1_s [NUM_CHANNELS];
  logic signed [DATA_WIDTH-1:0] line2_s [NUM_CHANNELS];
  logic signed [DATA_WIDTH-1:0] window_r [NUM_CHANNELS][3][3];

  assign accept_s    = pix_valid & pix_ready_r;
  assign col_last_s  = (col_r == COL_LAST);
  assign fill_done_s = accept_s & col_last_s & (row_r == ROW_ONE);
  assign beat_last_s = accept_s & col_last_s & (row_r == ROW_LAST) & (state_r == RUN);
  // Columns 0/1 would mix the tail of the previous line into the window.
  assign win_hit_s   = accept_s & (state_r == RUN) & (row_r >= ROW_TWO) & (col_r >= COL_TWO);

  // Line buffers: line1 holds the previous row, line2 the row before that.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH),
      .ADDR_W    (CW)
    ) u_line1 (
      .clk    (clk),
      .wr_en  (accept_s),
      .addr   (col_r),
      .wr_data(pix_in[g]),
      .rd_data(line1_s[g])
    );
    line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH),
      .ADDR_W    (CW)
    ) u_line2 (
      .clk    (clk),
      .wr_en  (accept_s),
      .addr   (col_r),
      .wr_data(line1_s[g]),
      .rd_data(line2_s[g])
    );
  end

  // Next-state and next pix_ready: FLUSH is a single stall cycle per frame.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FILL: begin
        if (fill_done_s) state_next_s = RUN;
        else             state_next_s = FILL;
      end
      RUN: begin
        if (beat_last_s) state_next_s = FLUSH;
        else             state_next_s = RUN;
      end
      FLUSH:   state_next_s = FILL;
      default: state_next_s = FILL;
    endcase
    ready_next_s = (state_next_s != FLUSH);
  end

  // State register and registered ready (held low through reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= FILL;
      pix_ready_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pix_ready_r <= ready_next_s;
    end
  end

  // Raster position of the next beat; wraps to (0,0) after the last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (accept_s) begin
      if (col_last_s) begin
        col_r <= {CW{1'b0}};
        row_r <= (row_r == ROW_LAST) ? {RW{1'b0}} : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Output pulses, one cycle after the qualifying accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_valid_r <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      window_valid_r <= win_hit_s;
      frame_done_r   <= beat_last_s;
    end
  end

  // Shift each window row left and load the new right column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            window_r[c][i][j] <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int i = 0; i < 3; i++) begin
          window_r[c][i][0] <= window_r[c][i][1];
          window_r[c][i][1] <= window_r[c][i][2];
        end
        window_r[c][0][2] <= line2_s[c];
        window_r[c][1][2] <= line1_s[c];
        window_r[c][2][2] <= pix_in[c];
      end
    end
  end

  assign pix_ready    = pix_ready_r;
  assign window_valid = window_valid_r;
  assign frame_done   = frame_done_r;
  assign window       = window_r;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Directed bench: 4x4x3 instance for window content/timing, default 32x32
// instance for per-frame pulse counts.
module tb_conv3x3_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s_pix_valid, s_pix_ready, s_window_valid, s_frame_done;
  logic signed [7:0] s_pix_in [0:2];
  logic signed [7:0] s_window [0:2][0:2][0:2];
  logic b_pix_valid, b_pix_ready, b_window_valid, b_frame_done;
  logic signed [7:0] b_pix_in [0:2];
  logic signed [7:0] b_window [0:2][0:2][0:2];

  int checks = 0;
  int errors = 0;

  int n_win = 0;
  int n_done = 0;
  int bad_pulse = 0;
  int ready_at_done = 0;
  logic acc_prev = 1'b0;
  int big_win = 0;
  int big_done = 0;
  logic [7:0] win_store [0:63][0:2][0:2][0:2];
  logic win_done [0:63];
  logic [15:0] gap_pat = 16'b1011_0010_1101_0110;

  conv3x3_window_gen #(.DATA_WIDTH(8), .NUM_CHANNELS(3), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_small (
    .clk(clk), .rst(rst), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .pix_in(s_pix_in),
    .window(s_window), .window_valid(s_window_valid), .frame_done(s_frame_done));

  conv3x3_window_gen u_big (
    .clk(clk), .rst(rst), .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .pix_in(b_pix_in),
    .window(b_window), .window_valid(b_window_valid), .frame_done(b_frame_done));

  // Capture windows of the small instance; note pulses not preceded by an accept.
  always @(negedge clk) begin
    if (rst) begin
      acc_prev <= 1'b0;
    end else begin
      if (s_window_valid) begin
        if (!acc_prev) bad_pulse <= bad_pulse + 1;
        if (n_win < 64) begin
          for (int c = 0; c < 3; c++)
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                win_store[n_win][c][i][j] <= s_window[c][i][j];
          win_done[n_win] <= s_frame_done;
        end
        n_win <= n_win + 1;
      end
      if (s_frame_done) begin
        n_done <= n_done + 1;
        ready_at_done <= int'(s_pix_ready);
      end
      acc_prev <= s_pix_valid && s_pix_ready;
    end
  end

  // Pulse counters of the 32x32 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (b_window_valid) big_win <= big_win + 1;
      if (b_frame_done) big_done <= big_done + 1;
    end
  end

  function automatic int pix_val(input int mode, input int base, input int ch, input int r, input int c);
    if (mode == 1) return (((r + c + ch) % 2) == 1) ? 127 : -128;
    return base + 16 * ch + 4 * r + c;
  endfunction

  task automatic idle(input int n);
    s_pix_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int mode, input int base, input bit gaps, input int nbeats);
    int k; int cyc; int r; int c; bit took;
    k = 0; cyc = 0;
    for (int b = 0; b < nbeats; b++) begin
      r = b / 4; c = b % 4; took = 1'b0;
      while (!took) begin
        s_pix_valid = gaps ? gap_pat[k % 16] : 1'b1;
        k++;
        for (int ch = 0; ch < 3; ch++) s_pix_in[ch] = 8'(pix_val(mode, base, ch, r, c));
        @(negedge clk);
        took = s_pix_valid && s_pix_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > 400) begin
          checks++; errors++;
          $display("FAIL send_timeout beat=%0d got no accept required accept", b);
          s_pix_valid = 1'b0;
          return;
        end
      end
    end
    s_pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (s_pix_ready !== 1'b0 || b_pix_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b/%b required 0/0", s_pix_ready, b_pix_ready);
    end
    checks++;
    if (s_window_valid !== 1'b0 || s_frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got %b/%b required 0/0", s_window_valid, s_frame_done);
    end
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          checks++;
          if (s_window[c][i][j] !== 8'sd0) begin
            errors++; $display("FAIL reset_window [%0d][%0d][%0d] got %0d required 0", c, i, j, s_window[c][i][j]);
          end
        end
  endtask

  task automatic test_basic();
    int w0; int d0; int bp0; int rr; int cc;
    w0 = n_win; d0 = n_done; bp0 = bad_pulse;
    send_frame(0, 0, 1'b0, 16);
    idle(4);
    checks++;
    if (n_win - w0 != 4) begin errors++; $display("FAIL basic_count got %0d required 4", n_win - w0); end
    checks++;
    if (n_done - d0 != 1) begin errors++; $display("FAIL basic_done got %0d required 1", n_done - d0); end
    checks++;
    if (bad_pulse != bp0) begin errors++; $display("FAIL basic_timing got %0d stray required 0", bad_pulse - bp0); end
    for (int w = 0; w < 4; w++) begin
      rr = 2 + w / 2; cc = 2 + w % 2;
      checks++;
      if (win_done[w0 + w] !== (w == 3)) begin
        errors++; $display("FAIL basic_done_align w=%0d got %b required %b", w, win_done[w0 + w], (w == 3));
      end
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            checks++;
            if (win_store[w0 + w][c][i][j] !== 8'(pix_val(0, 0, c, rr - 2 + i, cc - 2 + j))) begin
              errors++; $display("FAIL basic_win w=%0d c=%0d i=%0d j=%0d got %0d required %0d", w, c, i, j,
                                 win_store[w0 + w][c][i][j], pix_val(0, 0, c, rr - 2 + i, cc - 2 + j));
            end
          end
    end
    checks++;
    if (ready_at_done != 0) begin errors++; $display("FAIL basic_flush_ready got %0d required 0", ready_at_done); end
  endtask

  task automatic test_gaps();
    int w0; int bp0; int rr; int cc;
    w0 = n_win; bp0 = bad_pulse;
    send_frame(0, 0, 1'b1, 16);
    idle(4);
    checks++;
    if (n_win - w0 != 4) begin errors++; $display("FAIL gaps_count got %0d required 4", n_win - w0); end
    checks++;
    if (bad_pulse != bp0) begin errors++; $display("FAIL gaps_stray got %0d required 0", bad_pulse - bp0); end
    for (int w = 0; w < 4; w++) begin
      rr = 2 + w / 2; cc = 2 + w % 2;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            checks++;
            if (win_store[w0 + w][c][i][j] !== 8'(pix_val(0, 0, c, rr - 2 + i, cc - 2 + j))) begin
              errors++; $display("FAIL gaps_win w=%0d c=%0d i=%0d j=%0d got %0d required %0d", w, c, i, j,
                                 win_store[w0 + w][c][i][j], pix_val(0, 0, c, rr - 2 + i, cc - 2 + j));
            end
          end
    end
  endtask

  task automatic test_back_to_back();
    int w0; int d0; int rr; int cc; int base;
    logic [7:0] fifth_exp [0:8];
    logic [7:0] tmp;
    w0 = n_win; d0 = n_done;
    send_frame(0, 0, 1'b0, 16);
    send_frame(0, 100, 1'b0, 16);
    idle(4);
    checks++;
    if (n_win - w0 != 8) begin errors++; $display("FAIL b2b_count got %0d required 8", n_win - w0); end
    checks++;
    if (n_done - d0 != 2) begin errors++; $display("FAIL b2b_done got %0d required 2", n_done - d0); end
    fifth_exp = '{8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110};
    for (int k = 0; k < 9; k++) begin
      tmp = fifth_exp[k];
      checks++;
      if (win_store[w0 + 4][0][k / 3][k % 3] !== tmp) begin
        errors++; $display("FAIL b2b_fifth k=%0d got %0d required %0d", k, win_store[w0 + 4][0][k / 3][k % 3], tmp);
      end
    end
    for (int w = 0; w < 8; w++) begin
      rr = 2 + (w % 4) / 2; cc = 2 + w % 2; base = (w < 4) ? 0 : 100;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            checks++;
            if (win_store[w0 + w][c][i][j] !== 8'(pix_val(0, base, c, rr - 2 + i, cc - 2 + j))) begin
              errors++; $display("FAIL b2b_win w=%0d c=%0d i=%0d j=%0d got %0d required %0d", w, c, i, j,
                                 win_store[w0 + w][c][i][j], pix_val(0, base, c, rr - 2 + i, cc - 2 + j));
            end
          end
    end
  endtask

  task automatic test_reset_mid_frame();
    int w0; int d0; int rr; int cc;
    w0 = n_win; d0 = n_done;
    send_frame(0, 0, 1'b0, 7);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_pix_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b required 0", s_pix_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    checks++;
    if (n_win != w0 || n_done != d0) begin
      errors++; $display("FAIL mid_rst_aborted got %0d windows %0d done required 0 0", n_win - w0, n_done - d0);
    end
    w0 = n_win; d0 = n_done;
    send_frame(0, 50, 1'b0, 16);
    idle(4);
    checks++;
    if (n_win - w0 != 4 || n_done - d0 != 1) begin
      errors++; $display("FAIL mid_rst_count got %0d/%0d required 4/1", n_win - w0, n_done - d0);
    end
    for (int w = 0; w < 4; w++) begin
      rr = 2 + w / 2; cc = 2 + w % 2;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            checks++;
            if (win_store[w0 + w][c][i][j] !== 8'(pix_val(0, 50, c, rr - 2 + i, cc - 2 + j))) begin
              errors++; $display("FAIL mid_rst_win w=%0d c=%0d i=%0d j=%0d got %0d required %0d", w, c, i, j,
                                 win_store[w0 + w][c][i][j], pix_val(0, 50, c, rr - 2 + i, cc - 2 + j));
            end
          end
    end
  endtask

  task automatic test_signed_extremes();
    int w0; int rr; int cc; int sum_got; int sum_exp;
    w0 = n_win;
    send_frame(1, 0, 1'b0, 16);
    idle(4);
    checks++;
    if (n_win - w0 != 4) begin errors++; $display("FAIL ext_count got %0d required 4", n_win - w0); end
    for (int w = 0; w < 4; w++) begin
      rr = 2 + w / 2; cc = 2 + w % 2; sum_got = 0; sum_exp = 0;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            sum_got += int'($signed(win_store[w0 + w][c][i][j]));
            sum_exp += pix_val(1, 0, c, rr - 2 + i, cc - 2 + j);
            checks++;
            if (win_store[w0 + w][c][i][j] !== 8'(pix_val(1, 0, c, rr - 2 + i, cc - 2 + j))) begin
              errors++; $display("FAIL ext_win w=%0d c=%0d i=%0d j=%0d got %0d required %0d", w, c, i, j,
                                 $signed(win_store[w0 + w][c][i][j]), pix_val(1, 0, c, rr - 2 + i, cc - 2 + j));
            end
          end
      checks++;
      if (sum_got != sum_exp) begin errors++; $display("FAIL ext_sum w=%0d got %0d required %0d", w, sum_got, sum_exp); end
    end
  endtask

  task automatic test_full_frame();
    int w0; int d0; int cyc; bit took;
    w0 = big_win; d0 = big_done; cyc = 0;
    for (int b = 0; b < 1024; b++) begin
      took = 1'b0;
      while (!took && cyc <= 1300) begin
        b_pix_valid = 1'b1;
        for (int ch = 0; ch < 3; ch++) b_pix_in[ch] = 8'(b / 32 + b % 32 + ch);
        @(negedge clk);
        took = b_pix_valid && b_pix_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    b_pix_valid = 1'b0;
    checks++;
    if (cyc > 1300) begin errors++; $display("FAIL full_timeout got %0d cycles required <=1300", cyc); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (big_win - w0 != 900) begin errors++; $display("FAIL full_windows got %0d required 900", big_win - w0); end
    checks++;
    if (big_done - d0 != 1) begin errors++; $display("FAIL full_done got %0d required 1", big_done - d0); end
  endtask

  initial begin
    rst = 1'b1;
    s_pix_valid = 1'b0;
    b_pix_valid = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      s_pix_in[ch] = 8'sd0;
      b_pix_in[ch] = 8'sd0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    idle(2);
    test_basic();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_signed_extremes();
    test_full_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_window_gen.md
Name: conv3x3_window_gen

Overview:
Upstream feeder for the multi-channel 3x3 convolution core. Accepts a raster-order pixel stream (all channels of one pixel per beat) and buffers two previous image lines per channel. Emits one 3x3xNUM_CHANNELS window per valid output position: stride 1, no padding ("valid" convolution). The window output and window_valid connect directly to the core's data_in and valid_in.

Parameters:
DATA_WIDTH, 8, bits per pixel sample (signed)
NUM_CHANNELS, 3, channels per pixel
IMG_WIDTH, 32, pixels per line (>=3)
IMG_HEIGHT, 32, lines per frame (>=3)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
pix_valid  input  1  pixel beat offered
pix_ready  output  1  block accepts beat when pix_valid & pix_ready
pix_in  input  signed [DATA_WIDTH-1:0] x [0:NUM_CHANNELS-1]  one sample per channel
window  output  signed [DATA_WIDTH-1:0] x [0:NUM_CHANNELS-1][0:2][0:2]  current window
window_valid  output  1  one-cycle pulse per window
frame_done  output  1  one-cycle pulse after last window of frame

Behaviour:
- Reset (async, rst=1):
  - col/row counters = 0; state = FILL.
  - window_valid, frame_done = 0; window registers = 0; pix_ready = 0 while rst is high.
  - Line-buffer RAM contents need not reset.
- Accept = pix_valid & pix_ready. Only accepted beats advance counters or shift data.
- Counters:
  - col runs 0..IMG_WIDTH-1, then wraps to 0 and row increments.
  - row runs 0..IMG_HEIGHT-1.
- Storage: two line buffers per channel, each IMG_WIDTH deep, plus a 3x3 shift window per channel.
  - On accept, each window row shifts left by one column.
  - The new right column is {line2[col], line1[col], pix_in}.
  - line2[col] <= line1[col]; line1[col] <= pix_in.
- Window orientation: window[c][i][j] = pixel (row-2+i, col-2+j) of channel c. [2][2] is the newest pixel.
- window_valid:
  - Registered; asserts the cycle after accepting a pixel with row>=2 and col>=2.
  - window is stable for that cycle.
  - Latency is 1 cycle from accept. Count per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
  - No windows straddle a line wrap: col 0/1 beats of each line produce none.
- States:
  - FILL: rows 0-1; pix_ready=1; no windows. Moves to RUN when the beat (1, IMG_WIDTH-1) is accepted.
  - RUN: pix_ready=1; windows emitted per the rule above. Moves to FLUSH when the beat (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
  - FLUSH: exactly one cycle. pix_ready=0; frame_done=1 (coincides with the final window_valid); counters cleared. Then returns to FILL.
- pix_valid low: no shift, no counter change, window_valid=0. Bubbles are allowed anywhere, including mid-line.
- Back-to-back frames: the first beat of the next frame is accepted the cycle after FLUSH. There is no inter-frame leakage, because FILL suppresses windows until row 2.
- Reset mid-frame: the partial frame is discarded. The next accepted beat is treated as (0,0). No window_valid or frame_done pulse is generated for the aborted frame.
- Arithmetic: data is passed through unaltered with no sign or width changes. Counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).

Decomposition:
- Shared package cnn_pkg:
  - DATA_WIDTH default.
  - typedef pixel_t, the signed sample type.
  - typedef pix_vec_t [NUM_CHANNELS].
  - typedef window_t [NUM_CHANNELS][3][3], the same shape the conv core's data_in uses.
  - State enum {FILL, RUN, FLUSH}.
- One sub-module: line_buffer. Single-channel, IMG_WIDTH-deep, read-before-write at the same address. Instantiated 2xNUM_CHANNELS times via generate.

Test Plan:
1. IMG 4x4, NUM_CHANNELS=3, continuous valid; pixel(r,c) ch k = 16k+4r+c.
   - Expect exactly 4 window_valid pulses, at cycles following accepts of (2,2), (2,3), (3,2), (3,3).
   - First window ch0 = {0,1,2; 4,5,6; 8,9,10}; ch2 offset +32.
   - frame_done coincides with the 4th pulse, and pix_ready=0 for that one cycle.
2. Same stream with random pix_valid gaps (about 50% duty): identical window contents and order; window_valid never high on a cycle following a non-accepted cycle.
3. Two back-to-back 4x4 frames, the second with value +100: 8 windows total; the 5th window ch0 = {100,101,102; 104,105,106; 108,109,110}; no window mixes frames.
4. Assert rst after 7 accepted beats, deassert, then send a full frame: no pulses from the aborted frame; 4 correct windows for the new frame.
5. Signed extremes, with pixels alternating -128/127: window values bit-exact. Chain to the conv core with an all-ones kernel and zero bias; result equals the sum of the 27 window samples.
6. Default 32x32: exactly 900 window_valid pulses and exactly 1 frame_done.
